// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_unit
//  Purpose  : Instruction-fetch stage. Issues instruction-memory reads at the
//             current PC with at most one read outstanding, buffers returned
//             words in a small circular FIFO tagged with their fetch address,
//             and presents the head entry to the IF/ID register. Drives the
//             active-low PCWrite so the PC advances once per accepted fetch
//             and on every branch/jump redirect.
//  Ports    : clk, rst (sync, active low)
//             pc, pc_add_out         - current PC and PC+4 from the adder
//             flush, id_stall        - redirect / decode back-pressure
//             PCWrite                - 0 = PC loads next value, 1 = hold
//             imem_req/addr/gnt      - request channel to instruction memory
//             imem_rvalid/rdata      - response channel
//             if_valid/instr/pc/pc4  - buffer head towards decode
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
    parameter int                ADDR_W = 32,
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 2,
    parameter logic [DATA_W-1:0] NOP    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] pc_add_out,
    input  logic              flush,
    input  logic              id_stall,
    output logic              PCWrite,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc4
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LVL_W = CNT_W + 1;

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;  // nothing outstanding
    localparam logic [1:0] S_WAIT  = 2'd1;  // one live read outstanding
    localparam logic [1:0] S_DRAIN = 2'd2;  // outstanding read is stale

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [ADDR_W-1:0] pend_pc4_q, pend_pc4_d;

    logic [DATA_W-1:0] buf_instr_q [DEPTH];
    logic [DATA_W-1:0] buf_instr_d [DEPTH];
    logic [ADDR_W-1:0] buf_pc_q    [DEPTH];
    logic [ADDR_W-1:0] buf_pc_d    [DEPTH];
    logic [ADDR_W-1:0] buf_pc4_q   [DEPTH];
    logic [ADDR_W-1:0] buf_pc4_d   [DEPTH];

    logic              w_head_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_space;
    logic              w_grant;
    logic [LVL_W-1:0]  w_level;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                state_d = w_grant ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                // A response frees the slot; a same-cycle re-grant keeps us waiting.
                if (imem_rvalid) begin
                    state_d = w_grant ? S_WAIT : S_IDLE;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and handshake qualifiers
    // ------------------------------------------------------------------
    always_comb begin
        w_head_valid = rst & (count_q != '0);
        w_pop        = w_head_valid & ~id_stall & ~flush;
        w_push       = rst & (state_q == S_WAIT) & imem_rvalid & ~flush;
        // Occupancy after this cycle's pop/push; a request is only made
        // when the returning word is guaranteed a slot.
        w_level      = {1'b0, count_q} + LVL_W'(w_push) - LVL_W'(w_pop);
        w_space      = (w_level < DEPTH_LVL);
        imem_req     = rst & ~flush & w_space &
                       ((state_q == S_IDLE) | ((state_q == S_WAIT) & imem_rvalid));
        w_grant      = imem_req & imem_gnt;
        // PC advances exactly once per accepted fetch, or loads the redirect.
        PCWrite      = ~rst | ~(w_grant | flush);
    end

    // ------------------------------------------------------------------
    // Fetch buffer and pending-read tags: next values
    // ------------------------------------------------------------------
    always_comb begin
        count_d     = w_level[CNT_W-1:0];
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        pend_pc_d   = pend_pc_q;
        pend_pc4_d  = pend_pc4_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        buf_pc4_d   = buf_pc4_q;

        if (w_grant) begin
            pend_pc_d  = pc;
            pend_pc4_d = pc_add_out;
        end

        if (w_push) begin
            buf_instr_d[wr_ptr_q] = imem_rdata;
            buf_pc_d[wr_ptr_q]    = pend_pc_q;
            buf_pc4_d[wr_ptr_q]   = pend_pc4_q;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end

        if (w_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        // A redirect invalidates everything buffered, whatever else happens.
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            pend_pc_q  <= '0;
            pend_pc4_q <= '0;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            pend_pc_q  <= pend_pc_d;
            pend_pc4_q <= pend_pc4_d;
        end
    end

    // Buffer payload needs no reset: it is only observed through if_valid.
    always_ff @(posedge clk) begin
        buf_instr_q <= buf_instr_d;
        buf_pc_q    <= buf_pc_d;
        buf_pc4_q   <= buf_pc4_d;
    end

    // ------------------------------------------------------------------
    // Outputs: head registers only, no path from imem_rdata
    // ------------------------------------------------------------------
    assign imem_addr = pc;
    assign if_valid  = w_head_valid;
    assign if_instr  = w_head_valid ? buf_instr_q[rd_ptr_q] : NOP;
    assign if_pc     = buf_pc_q[rd_ptr_q];
    assign if_pc4    = buf_pc4_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_unit
//  Purpose  : Self-checking bench for inst_fetch_unit. Models the PC register
//             and a single-outstanding instruction memory around the DUT, and
//             keeps a queue-based reference of the fetch stream that is
//             compared against the DUT every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    localparam int M_NONE    = 0;
    localparam int M_LIVE    = 1;
    localparam int M_DISCARD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc = 32'h0;
    logic [31:0] pc_add_out;
    logic        flush;
    logic        id_stall;
    logic        PCWrite;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;

    logic [31:0] reset_pc;
    logic [31:0] flush_tgt;
    int          mem_lat;
    logic        mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = 32'h0;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_state = M_NONE;
    logic [31:0] m_pend_pc = 32'h0;
    logic [31:0] mq_instr[$];
    logic [31:0] mq_pc[$];
    logic [31:0] mq_pc4[$];

    inst_fetch_unit #(
        .ADDR_W(32),
        .DATA_W(32),
        .DEPTH (DEPTH),
        .NOP   (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_add_out (pc_add_out),
        .flush      (flush),
        .id_stall   (id_stall),
        .PCWrite    (PCWrite),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_pc4     (if_pc4)
    );

    always #5 clk = ~clk;

    // PC register: loads reset vector, redirect target, or pc+4 when PCWrite=0
    assign pc_add_out = pc + 32'd4;
    always @(posedge clk) begin
        if (!rst)          pc <= reset_pc;
        else if (!PCWrite) pc <= flush ? flush_tgt : pc + 32'd4;
    end

    // Instruction memory: word at address A is ~A, response mem_lat cycles after grant
    assign imem_rvalid = mem_busy && (mem_cnt == 0);
    assign imem_rdata  = ~mem_addr;
    always @(posedge clk) begin
        if (imem_rvalid) mem_busy <= 1'b0;
        if (imem_req && imem_gnt) begin
            mem_busy <= 1'b1;
            mem_cnt  <= mem_lat - 1;
            mem_addr <= imem_addr;
        end else if (mem_busy && mem_cnt != 0) begin
            mem_cnt <= mem_cnt - 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the reference model, then model update
    always @(negedge clk) begin
        logic m_valid, m_pop, m_push, m_req, m_gnt;
        int   lvl;
        if (!rst) begin
            chk("rst_req", imem_req, 1'b0);
            chk("rst_pcwrite", PCWrite, 1'b1);
            chk("rst_valid", if_valid, 1'b0);
            chk("rst_instr", if_instr, NOP);
            mq_instr.delete();
            mq_pc.delete();
            mq_pc4.delete();
            m_state = M_NONE;
        end else begin
            m_valid = (mq_pc.size() != 0);
            m_pop   = m_valid && !id_stall && !flush;
            m_push  = (m_state == M_LIVE) && imem_rvalid && !flush;
            lvl     = mq_pc.size() - int'(m_pop) + int'(m_push);
            m_req   = !flush && (lvl < DEPTH) &&
                      (m_state == M_NONE || (m_state == M_LIVE && imem_rvalid));
            m_gnt   = m_req && imem_gnt;

            chk("m_req", imem_req, m_req);
            chk("m_pcwrite", PCWrite, !(m_gnt || flush));
            chk("m_valid", if_valid, m_valid);
            chk("m_instr", if_instr, m_valid ? mq_instr[0] : NOP);
            if (m_valid) begin
                chk("m_if_pc", if_pc, mq_pc[0]);
                chk("m_if_pc4", if_pc4, mq_pc4[0]);
            end
            if (m_req) chk("m_addr", imem_addr, pc);
            chk("one_outstanding", imem_req && imem_gnt && mem_busy && !imem_rvalid, 1'b0);

            if (flush) begin
                mq_instr.delete();
                mq_pc.delete();
                mq_pc4.delete();
            end else begin
                if (m_pop) begin
                    void'(mq_instr.pop_front());
                    void'(mq_pc.pop_front());
                    void'(mq_pc4.pop_front());
                end
                if (m_push) begin
                    mq_instr.push_back(~m_pend_pc);
                    mq_pc.push_back(m_pend_pc);
                    mq_pc4.push_back(m_pend_pc + 32'd4);
                end
            end

            if (m_gnt)                                    m_state = M_LIVE;
            else if (m_state == M_LIVE && !imem_rvalid)   m_state = flush ? M_DISCARD : M_LIVE;
            else if (m_state == M_DISCARD && !imem_rvalid) m_state = M_DISCARD;
            else                                          m_state = M_NONE;
            if (m_gnt) m_pend_pc = pc;
        end
    end

    task automatic step(input logic s, input logic g, input logic f, input logic [31:0] t);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        id_stall  = s;
        imem_gnt  = g;
        flush     = f;
        flush_tgt = t;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [31:0] rpc, input logic g);
        repeat (2) begin
            @(posedge clk);
            #1;
            rst      = 1'b0;
            id_stall = 1'b0;
            imem_gnt = g;
            flush    = 1'b0;
            reset_pc = rpc;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; id_stall = 1'b0; imem_gnt = 1'b1; flush = 1'b0;
        flush_tgt = 32'h0; reset_pc = 32'h0; mem_lat = 1;

        // 1: reset holds everything quiet even with gnt=1
        do_reset(32'h0, 1'b1);
        chk("t1_req", imem_req, 1'b0);
        chk("t1_pcwrite", PCWrite, 1'b1);
        chk("t1_valid", if_valid, 1'b0);
        chk("t1_instr", if_instr, 32'h0);

        // 2: back-to-back stream, one instruction per cycle
        step(0, 1, 0, 0); chk("t2_pcw_g0", PCWrite, 1'b0); chk("t2_addr_g0", imem_addr, 32'h0);
        step(0, 1, 0, 0); chk("t2_pcw_g1", PCWrite, 1'b0); chk("t2_addr_g1", imem_addr, 32'h4);
        step(0, 1, 0, 0); chk("t2_pc_0", if_pc, 32'h0); chk("t2_pc4_0", if_pc4, 32'h4);
                          chk("t2_instr_0", if_instr, 32'hFFFF_FFFF);
        step(0, 1, 0, 0); chk("t2_pc_1", if_pc, 32'h4);
        step(0, 1, 0, 0); chk("t2_pc_2", if_pc, 32'h8); chk("t2_pc4_2", if_pc4, 32'hC);
        repeat (4) step(0, 0, 0, 0);

        // 3: decode stalled from the start, then released
        do_reset(32'h0, 1'b0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0); chk("t3_req_full", imem_req, 1'b0); chk("t3_pcw_full", PCWrite, 1'b1);
        step(1, 1, 0, 0); chk("t3_req_hold", imem_req, 1'b0); chk("t3_pc_hold", if_pc, 32'h0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0); chk("t3_pc_0", if_pc, 32'h0);
        step(0, 1, 0, 0); chk("t3_pc_1", if_pc, 32'h4);
        step(0, 1, 0, 0); chk("t3_pc_2", if_pc, 32'h8);
        repeat (4) step(0, 0, 0, 0);

        // 4: flush while the 0x10 read is outstanding
        do_reset(32'h10, 1'b0);
        mem_lat = 2;
        step(0, 1, 0, 0);        chk("t4_addr_g", imem_addr, 32'h10); chk("t4_pcw_g", PCWrite, 1'b0);
        step(0, 1, 1, 32'h40);   chk("t4_pcw_flush", PCWrite, 1'b0); chk("t4_req_flush", imem_req, 1'b0);
        mem_lat = 1;
        step(0, 1, 0, 0);        chk("t4_req_drain", imem_req, 1'b0);
        step(0, 1, 0, 0);        chk("t4_req_new", imem_req, 1'b1); chk("t4_addr_new", imem_addr, 32'h40);
        step(0, 0, 0, 0);        chk("t4_no_stale", if_valid, 1'b0);
        step(0, 0, 0, 0);        chk("t4_valid", if_valid, 1'b1); chk("t4_pc", if_pc, 32'h40);
                                 chk("t4_instr", if_instr, ~32'h40);
        repeat (2) step(0, 0, 0, 0);

        // 5: flush in the same cycle as a response, one entry buffered
        do_reset(32'h80, 1'b0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 32'h100); chk("t5_valid_pre", if_valid, 1'b1); chk("t5_req_flush", imem_req, 1'b0);
        step(0, 0, 0, 0);       chk("t5_empty", if_valid, 1'b0); chk("t5_idle_req", imem_req, 1'b1);
                                chk("t5_addr", imem_addr, 32'h100);
        repeat (2) step(0, 0, 0, 0);

        // 6: memory wait states
        do_reset(32'h20, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            chk("t6_req_wait", imem_req, 1'b1);
            chk("t6_addr_wait", imem_addr, 32'h20);
            chk("t6_pcw_wait", PCWrite, 1'b1);
        end
        step(0, 1, 0, 0); chk("t6_pcw_gnt", PCWrite, 1'b0);
        step(0, 0, 0, 0); chk("t6_pcw_after", PCWrite, 1'b1); chk("t6_addr_after", imem_addr, 32'h24);
        repeat (2) step(0, 0, 0, 0);

        // 7: reset while a slow read is outstanding; the late response is ignored
        do_reset(32'h60, 1'b0);
        mem_lat = 3;
        step(0, 1, 0, 0);
        @(posedge clk); #1; rst = 1'b0; imem_gnt = 1'b0; @(negedge clk);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0); chk("t7_ignored", if_valid, 1'b0);

        // 8: mixed stall / wait-state / flush pattern exercising pointer wrap
        do_reset(32'h0, 1'b0);
        for (int i = 0; i < 48; i++) begin
            mem_lat = (i % 4 == 0) ? 2 : 1;
            step((i % 3) == 0, (i % 5) != 4, (i == 20) || (i == 33), 32'h200 + 32'(i * 16));
        end
        repeat (4) step(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
